register_file_param: RTL and testbench

Parametrised general-purpose register file for the datapath. It provides a configurable data width, register count and number of combinational read ports, plus a single synchronous write port. Write-to-read bypass is optional, and register 0 can be hardwired to zero. A per-register busy scoreboard lets the issue logic stall on registers with a pending writer. It sits between decode (read/reserve) and writeback (write).

---
 rtl/register_file_pkg.sv | 12 +
 rtl/register_file_read_port.sv | 38 +++
 rtl/register_file_param.sv | 84 ++++++++
 tb/tb_register_file_param.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/register_file_pkg.sv
// Shared constants and helpers for the parametrised register file.
package register_file_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH  = 16;
  localparam int unsigned DEFAULT_INDEX_WIDTH = 2;

  // Number of registers addressed by an index of the given width.
  function automatic int unsigned rf_depth(input int unsigned index_width);
    return 32'd1 << index_width;
  endfunction

endpackage

// File: rtl/register_file_read_port.sv
// One combinational read port: index mux, write bypass, zero-register override, busy select.
module register_file_read_port
  import register_file_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int unsigned INDEX_WIDTH = DEFAULT_INDEX_WIDTH,
  parameter bit          BYPASS      = 1'b1,
  parameter bit          ZERO_REG    = 1'b0,
  localparam int unsigned DEPTH      = rf_depth(INDEX_WIDTH)
) (
  input  logic [DEPTH-1:0][DATA_WIDTH-1:0] regs,
  input  logic [DEPTH-1:0]                 busy,
  input  logic [INDEX_WIDTH-1:0]           read_index,
  input  logic                             write_fire,
  input  logic [INDEX_WIDTH-1:0]           write_index,
  input  logic [DATA_WIDTH-1:0]            write_data,
  input  logic                             reserve_fire,
  input  logic [INDEX_WIDTH-1:0]           reserve_index,
  output logic [DATA_WIDTH-1:0]            read_data,
  output logic                             read_busy
);

  // Stored value, then same-cycle forwarding, then the hardwired-zero override.
  always_comb begin
    read_data = regs[read_index];
    read_busy = busy[read_index];
    if (BYPASS && write_fire && (write_index == read_index)) begin
      read_data = write_data;
      // A reservation landing on the same edge is a newer producer than this write.
      read_busy = reserve_fire && (reserve_index == read_index);
    end
    if (ZERO_REG && (read_index == '0)) begin
      read_data = '0;
      read_busy = 1'b0;
    end
  end

endmodule

// File: rtl/register_file_param.sv
// Parametrised register file: one write port, N_READ read ports, per-register busy scoreboard.
module register_file_param
  import register_file_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int unsigned INDEX_WIDTH = DEFAULT_INDEX_WIDTH,
  parameter int unsigned N_READ      = 2,
  parameter bit          BYPASS      = 1'b1,
  parameter bit          ZERO_REG    = 1'b0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [N_READ*INDEX_WIDTH-1:0] read_index,
  output logic [N_READ*DATA_WIDTH-1:0]  read_data,
  output logic [N_READ-1:0]             read_busy,
  input  logic                          write_enable,
  input  logic [INDEX_WIDTH-1:0]        write_index,
  input  logic [DATA_WIDTH-1:0]         write_data,
  input  logic                          reserve_enable,
  input  logic [INDEX_WIDTH-1:0]        reserve_index,
  output logic                          any_busy
);

  localparam int unsigned DEPTH = rf_depth(INDEX_WIDTH);

  logic [DEPTH-1:0][DATA_WIDTH-1:0] regs_q, regs_d;
  logic [DEPTH-1:0]                 busy_q, busy_d;
  logic                             write_fire;
  logic                             reserve_fire;

  // Qualified actions: nothing fires under reset, and register 0 drops them when hardwired.
  always_comb begin
    write_fire   = write_enable && !reset && !(ZERO_REG && (write_index == '0));
    reserve_fire = reserve_enable && !reset && !(ZERO_REG && (reserve_index == '0));
  end

  // Next storage/busy state; reserve is applied last so a new producer wins over the write.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (write_fire) begin
      regs_d[write_index] = write_data;
      busy_d[write_index] = 1'b0;
    end
    if (reserve_fire) begin
      busy_d[reserve_index] = 1'b1;
    end
  end

  // Storage and busy registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs_q <= '0;
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  assign any_busy = |busy_q;

  // Independent read ports.
  for (genvar p = 0; p < int'(N_READ); p++) begin : g_read
    register_file_read_port #(
      .DATA_WIDTH (DATA_WIDTH),
      .INDEX_WIDTH(INDEX_WIDTH),
      .BYPASS     (BYPASS),
      .ZERO_REG   (ZERO_REG)
    ) u_read_port (
      .regs         (regs_q),
      .busy         (busy_q),
      .read_index   (read_index[p*INDEX_WIDTH +: INDEX_WIDTH]),
      .write_fire   (write_fire),
      .write_index  (write_index),
      .write_data   (write_data),
      .reserve_fire (reserve_fire),
      .reserve_index(reserve_index),
      .read_data    (read_data[p*DATA_WIDTH +: DATA_WIDTH]),
      .read_busy    (read_busy[p])
    );
  end

endmodule

// File: tb/tb_register_file_param.sv
// Scoreboard bench: three configurations driven by shared stimulus, checked against an array model.
module tb_register_file_param;

  logic             clk = 1'b0;
  logic             reset;
  logic             we;
  logic [3:0]       wi;
  logic [31:0]      wd;
  logic             re;
  logic [3:0]       ri;
  logic [2:0][3:0]  rdi;

  // Instance A: 16b x 4, 2 ports, bypass, no zero reg.
  logic [31:0] rd_a;  logic [1:0] rb_a;  logic any_a;
  // Instance Z: 16b x 4, 2 ports, bypass, zero reg.
  logic [31:0] rd_z;  logic [1:0] rb_z;  logic any_z;
  // Instance W: 32b x 16, 3 ports, no bypass.
  logic [95:0] rd_w;  logic [2:0] rb_w;  logic any_w;

  always #5 clk = ~clk;

  register_file_param #(.DATA_WIDTH(16), .INDEX_WIDTH(2), .N_READ(2), .BYPASS(1'b1), .ZERO_REG(1'b0)) dut_a (
    .clk(clk), .reset(reset),
    .read_index({rdi[1][1:0], rdi[0][1:0]}), .read_data(rd_a), .read_busy(rb_a),
    .write_enable(we), .write_index(wi[1:0]), .write_data(wd[15:0]),
    .reserve_enable(re), .reserve_index(ri[1:0]), .any_busy(any_a));

  register_file_param #(.DATA_WIDTH(16), .INDEX_WIDTH(2), .N_READ(2), .BYPASS(1'b1), .ZERO_REG(1'b1)) dut_z (
    .clk(clk), .reset(reset),
    .read_index({rdi[1][1:0], rdi[0][1:0]}), .read_data(rd_z), .read_busy(rb_z),
    .write_enable(we), .write_index(wi[1:0]), .write_data(wd[15:0]),
    .reserve_enable(re), .reserve_index(ri[1:0]), .any_busy(any_z));

  register_file_param #(.DATA_WIDTH(32), .INDEX_WIDTH(4), .N_READ(3), .BYPASS(1'b0), .ZERO_REG(1'b0)) dut_w (
    .clk(clk), .reset(reset),
    .read_index({rdi[2], rdi[1], rdi[0]}), .read_data(rd_w), .read_busy(rb_w),
    .write_enable(we), .write_index(wi), .write_data(wd),
    .reserve_enable(re), .reserve_index(ri), .any_busy(any_w));

  // Per-configuration parameters seen by the model.
  int cfg_dw [3] = '{16, 16, 32};
  int cfg_iw [3] = '{2, 2, 4};
  int cfg_nr [3] = '{2, 2, 3};
  bit cfg_by [3] = '{1'b1, 1'b1, 1'b0};
  bit cfg_zr [3] = '{1'b0, 1'b1, 1'b0};

  // Reference model state.
  logic [31:0] mem [3][16];
  logic        bsy [3][16];

  typedef struct packed {
    logic [2:0][31:0] data;
    logic [2:0]       busy;
    logic             anyb;
  } exp_one_t;
  typedef exp_one_t [2:0] exp_all_t;

  exp_all_t sb_q[$];
  int n_vec  = 0;
  int n_miss = 0;

  function automatic logic [31:0] dmask(int k);
    return (cfg_dw[k] == 32) ? 32'hFFFF_FFFF : ((32'd1 << cfg_dw[k]) - 32'd1);
  endfunction

  function automatic logic [3:0] imask(int k);
    return 4'((32'd1 << cfg_iw[k]) - 32'd1);
  endfunction

  // Outputs expected in the current cycle, from the model and the applied inputs.
  function automatic exp_all_t model_outs(logic rst_i, logic we_i, logic [3:0] wi_i, logic [31:0] wd_i,
                                          logic re_i, logic [3:0] ri_i, logic [2:0][3:0] rd_i);
    exp_all_t e;
    e = '0;
    for (int k = 0; k < 3; k++) begin
      logic [3:0] wix, rix, ix;
      logic wen, ren;
      wix = wi_i & imask(k);
      rix = ri_i & imask(k);
      wen = we_i && !(cfg_zr[k] && wix == 4'd0);
      ren = re_i && !(cfg_zr[k] && rix == 4'd0);
      if (!rst_i) begin
        for (int r = 0; r < (1 << cfg_iw[k]); r++) e[k].anyb |= bsy[k][r];
        for (int p = 0; p < cfg_nr[k]; p++) begin
          ix = rd_i[p] & imask(k);
          e[k].data[p] = mem[k][ix];
          e[k].busy[p] = bsy[k][ix];
          if (cfg_by[k] && wen && wix == ix) begin
            e[k].data[p] = wd_i & dmask(k);
            e[k].busy[p] = ren && (rix == ix);
          end
          if (cfg_zr[k] && ix == 4'd0) begin
            e[k].data[p] = 32'd0;
            e[k].busy[p] = 1'b0;
          end
        end
      end
    end
    return e;
  endfunction

  // Model state change at a rising edge.
  task automatic model_edge(logic rst_i, logic we_i, logic [3:0] wi_i, logic [31:0] wd_i,
                            logic re_i, logic [3:0] ri_i);
    for (int k = 0; k < 3; k++) begin
      logic [3:0] wix, rix;
      wix = wi_i & imask(k);
      rix = ri_i & imask(k);
      if (rst_i) begin
        for (int r = 0; r < 16; r++) begin
          mem[k][r] = 32'd0;
          bsy[k][r] = 1'b0;
        end
      end else begin
        if (we_i && !(cfg_zr[k] && wix == 4'd0)) begin
          mem[k][wix] = wd_i & dmask(k);
          bsy[k][wix] = 1'b0;
        end
        if (re_i && !(cfg_zr[k] && rix == 4'd0)) bsy[k][rix] = 1'b1;
      end
    end
  endtask

  // Drive one cycle of inputs, queue the expected outputs, then advance past the edge.
  task automatic step(logic rst_i, logic we_i, logic [3:0] wi_i, logic [31:0] wd_i,
                      logic re_i, logic [3:0] ri_i, logic [3:0] r0, logic [3:0] r1, logic [3:0] r2);
    logic [2:0][3:0] rd_v;
    rd_v = {r2, r1, r0};
    reset = rst_i; we = we_i; wi = wi_i; wd = wd_i; re = re_i; ri = ri_i; rdi = rd_v;
    sb_q.push_back(model_outs(rst_i, we_i, wi_i, wd_i, re_i, ri_i, rd_v));
    @(posedge clk);
    model_edge(rst_i, we_i, wi_i, wd_i, re_i, ri_i);
    #1;
  endtask

  function automatic logic [31:0] act_data(int k, int p);
    case (k)
      0:       return 32'(rd_a[p*16 +: 16]);
      1:       return 32'(rd_z[p*16 +: 16]);
      default: return rd_w[p*32 +: 32];
    endcase
  endfunction

  function automatic logic act_busy(int k, int p);
    case (k)
      0:       return rb_a[p];
      1:       return rb_z[p];
      default: return rb_w[p];
    endcase
  endfunction

  function automatic logic act_any(int k);
    case (k)
      0:       return any_a;
      1:       return any_z;
      default: return any_w;
    endcase
  endfunction

  task automatic chk(string name, int k, int p, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s inst=%0d port=%0d t=%0t got=%h expected=%h", name, k, p, $time, act, exp);
    end
  endtask

  // Monitor: outputs are valid mid-cycle; pop one expectation per falling edge.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_all_t e;
      e = sb_q.pop_front();
      for (int k = 0; k < 3; k++) begin
        for (int p = 0; p < cfg_nr[k]; p++) begin
          chk("read_data", k, p, act_data(k, p), e[k].data[p]);
          chk("read_busy", k, p, 32'(act_busy(k, p)), 32'(e[k].busy[p]));
        end
        chk("any_busy", k, 0, 32'(act_any(k)), 32'(e[k].anyb));
      end
    end
  end

  initial begin
    reset = 1'b1; we = 1'b0; wi = '0; wd = '0; re = 1'b0; ri = '0; rdi = '0;
    for (int k = 0; k < 3; k++)
      for (int r = 0; r < 16; r++) begin
        mem[k][r] = 32'd0;
        bsy[k][r] = 1'b0;
      end
    @(posedge clk);
    #1;

    // Reset: every index reads zero, not busy.
    for (int i = 0; i < 16; i++) step(1, 0, 0, 0, 0, 0, 4'(i), 4'(i ^ 1), 4'(15 - i));

    // Consecutive writes, bypass during the write cycle.
    step(0, 1, 0, 3, 0, 0, 0, 1, 15);
    step(0, 1, 1, 7, 0, 0, 0, 1, 15);
    step(0, 0, 0, 0, 0, 0, 0, 1, 15);

    // Reserve, write clears, same-edge reserve+write keeps busy.
    step(0, 0, 0, 0, 1, 2, 2, 1, 2);
    step(0, 1, 2, 10, 0, 0, 2, 2, 2);
    step(0, 1, 2, 10, 1, 2, 2, 0, 2);
    step(0, 0, 0, 0, 0, 0, 2, 2, 2);

    // Register 0 writes/reserves, then a normal write to reg 1.
    step(0, 1, 0, 5, 1, 0, 0, 1, 0);
    step(0, 1, 1, 5, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);

    // Reset mid-operation discards pending write/reserve.
    step(0, 1, 1, 7, 1, 1, 1, 1, 1);
    step(0, 0, 0, 0, 0, 0, 1, 1, 1);
    step(1, 1, 1, 9, 1, 1, 1, 1, 1);
    step(0, 0, 0, 0, 0, 0, 1, 1, 1);

    // Wide write to the top register: no forwarding in the wide config.
    step(0, 1, 15, 32'hDEAD_BEEF, 0, 0, 15, 15, 15);
    step(0, 0, 0, 0, 0, 0, 15, 15, 15);

    // Random traffic with occasional resets.
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 49) == 0), 1'($urandom), 4'($urandom), $urandom,
           1'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
    end
    reset = 1'b0; we = 1'b0; re = 1'b0;

    @(negedge clk);
    #1;
    n_vec++;
    if (sb_q.size() != 0) begin
      n_miss++;
      $display("FAIL scoreboard_drain left=%0d expected=0", sb_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
